stepper_mul_sequencer: RTL and testbench

Multi-cycle 32x32 multiply sequencer that drives one shared, externally instantiated 16x16 unsigned registered multiplier through four partial-product passes. It accumulates a full 64-bit product, applies signedness correction and returns either the low or high 32-bit word. It sits beside the CPU multiply cell as the controller for the custom-instruction and peripheral multiply path, using a valid/ready handshake on both sides with one operation in flight.

---
 rtl/stepper_mul_sequencer.sv | 157 +++++++++++++++
 tb/tb_stepper_mul_sequencer.sv | 270 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/stepper_mul_sequencer.sv
// stepper_mul_sequencer: 32x32 multiply sequencer built on an external
// 16x16 registered multiplier. Four partial-product passes are issued
// back to back, their products accumulated into a 64-bit sum, and the high
// word is sign-corrected before the requested 32-bit word is returned.
module stepper_mul_sequencer #(
  parameter int unsigned MUL_PIPE = 1
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [1:0]  in_op,
  input  logic [31:0] in_a,
  input  logic [31:0] in_b,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [31:0] out_result,
  output logic        busy,
  output logic        mul_en,
  output logic [15:0] mul_a,
  output logic [15:0] mul_b,
  input  logic [31:0] mul_p
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_ISSUE,
    S_DRAIN,
    S_FIX,
    S_DONE
  } state_e;

  typedef enum logic [1:0] {
    OP_MUL    = 2'b00,
    OP_MULXSS = 2'b01,
    OP_MULXSU = 2'b10,
    OP_MULXUU = 2'b11
  } op_e;

  // Cycle index within ISSUE/DRAIN: 0..3 issue passes, then MUL_PIPE drain
  // cycles. Pass k is sampled in the cycle whose index is k+MUL_PIPE.
  localparam logic [2:0] LAST_ISSUE   = 3'd3;
  localparam logic [2:0] FIRST_SAMPLE = 3'(MUL_PIPE);
  localparam logic [2:0] LAST_SAMPLE  = 3'(MUL_PIPE + 3);

  state_e      state_q, state_d;
  logic [2:0]  cyc_q, cyc_d;
  logic [31:0] a_q, a_d;
  logic [31:0] b_q, b_d;
  logic [1:0]  op_q, op_d;
  logic [63:0] acc_q, acc_d;
  logic [31:0] res_q, res_d;

  logic [2:0]  samp_k;
  logic        samp_en;
  logic [31:0] hi_fix;

  assign out_result = res_q;

  // State and datapath registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= S_IDLE;
      cyc_q   <= '0;
      a_q     <= '0;
      b_q     <= '0;
      op_q    <= '0;
      acc_q   <= '0;
      res_q   <= '0;
    end else begin
      state_q <= state_d;
      cyc_q   <= cyc_d;
      a_q     <= a_d;
      b_q     <= b_d;
      op_q    <= op_d;
      acc_q   <= acc_d;
      res_q   <= res_d;
    end
  end

  // Next-state, pass issue, product accumulation and sign fix-up.
  always_comb begin
    state_d   = state_q;
    cyc_d     = cyc_q;
    a_d       = a_q;
    b_d       = b_q;
    op_d      = op_q;
    acc_d     = acc_q;
    res_d     = res_q;
    in_ready  = 1'b0;
    busy      = 1'b1;
    out_valid = 1'b0;
    mul_en    = 1'b0;
    mul_a     = '0;
    mul_b     = '0;
    hi_fix    = acc_q[63:32];

    // Issue and drain overlap: a pass result can land while later passes
    // are still being issued, so sampling keys off the cycle index only.
    samp_k  = cyc_q - FIRST_SAMPLE;
    samp_en = ((state_q == S_ISSUE) || (state_q == S_DRAIN)) &&
              (cyc_q >= FIRST_SAMPLE) && (cyc_q <= LAST_SAMPLE);
    if (samp_en) begin
      case (samp_k)
        3'd0:    acc_d = acc_q + {32'h0, mul_p};
        3'd1,
        3'd2:    acc_d = acc_q + {16'h0, mul_p, 16'h0};
        3'd3:    acc_d = acc_q + {mul_p, 32'h0};
        default: acc_d = acc_q;
      endcase
    end

    case (state_q)
      S_IDLE: begin
        busy     = 1'b0;
        in_ready = 1'b1;
        if (in_valid) begin
          a_d     = in_a;
          b_d     = in_b;
          op_d    = in_op;
          acc_d   = '0;
          cyc_d   = '0;
          state_d = S_ISSUE;
        end
      end
      S_ISSUE: begin
        mul_en = 1'b1;
        case (cyc_q)
          3'd0:    begin mul_a = a_q[15:0];  mul_b = b_q[15:0];  end
          3'd1:    begin mul_a = a_q[31:16]; mul_b = b_q[15:0];  end
          3'd2:    begin mul_a = a_q[15:0];  mul_b = b_q[31:16]; end
          default: begin mul_a = a_q[31:16]; mul_b = b_q[31:16]; end
        endcase
        cyc_d = cyc_q + 3'd1;
        if (cyc_q == LAST_ISSUE) state_d = S_DRAIN;
      end
      S_DRAIN: begin
        cyc_d = cyc_q + 3'd1;
        if (cyc_q == LAST_SAMPLE) state_d = S_FIX;
      end
      S_FIX: begin
        if (((op_q == OP_MULXSS) || (op_q == OP_MULXSU)) && a_q[31])
          hi_fix = hi_fix - b_q;
        if ((op_q == OP_MULXSS) && b_q[31])
          hi_fix = hi_fix - a_q;
        res_d   = (op_q == OP_MUL) ? acc_q[31:0] : hi_fix;
        state_d = S_DONE;
      end
      S_DONE: begin
        out_valid = 1'b1;
        if (out_ready) state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

endmodule

// File: tb/tb_stepper_mul_sequencer.sv
// Bench for stepper_mul_sequencer: two instances (MUL_PIPE=1 and 3), each
// driving a behavioural registered 16x16 multiplier; results checked
// against a 64-bit reference through a scoreboard queue.
module tb_stepper_mul_sequencer;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  int checks   = 0;
  int failures = 0;

  // Instance with MUL_PIPE=1
  logic        reset1, in_valid1, out_ready1;
  logic [1:0]  in_op1;
  logic [31:0] in_a1, in_b1;
  logic        in_ready1, out_valid1, busy1, mul_en1;
  logic [31:0] out_result1, mul_p1;
  logic [15:0] mul_a1, mul_b1;

  // Instance with MUL_PIPE=3
  logic        reset3, in_valid3, out_ready3;
  logic [1:0]  in_op3;
  logic [31:0] in_a3, in_b3;
  logic        in_ready3, out_valid3, busy3, mul_en3;
  logic [31:0] out_result3, mul_p3;
  logic [15:0] mul_a3, mul_b3;

  stepper_mul_sequencer #(.MUL_PIPE(1)) dut1 (
    .clk(clk), .reset(reset1), .in_valid(in_valid1), .in_ready(in_ready1),
    .in_op(in_op1), .in_a(in_a1), .in_b(in_b1), .out_valid(out_valid1),
    .out_ready(out_ready1), .out_result(out_result1), .busy(busy1),
    .mul_en(mul_en1), .mul_a(mul_a1), .mul_b(mul_b1), .mul_p(mul_p1)
  );

  stepper_mul_sequencer #(.MUL_PIPE(3)) dut3 (
    .clk(clk), .reset(reset3), .in_valid(in_valid3), .in_ready(in_ready3),
    .in_op(in_op3), .in_a(in_a3), .in_b(in_b3), .out_valid(out_valid3),
    .out_ready(out_ready3), .out_result(out_result3), .busy(busy3),
    .mul_en(mul_en3), .mul_a(mul_a3), .mul_b(mul_b3), .mul_p(mul_p3)
  );

  // External multiplier models
  logic [31:0] p1_q;
  logic [31:0] p3_q [3];
  always_ff @(posedge clk) begin
    p1_q    <= {16'h0, mul_a1} * {16'h0, mul_b1};
    p3_q[0] <= {16'h0, mul_a3} * {16'h0, mul_b3};
    p3_q[1] <= p3_q[0];
    p3_q[2] <= p3_q[1];
  end
  assign mul_p1 = p1_q;
  assign mul_p3 = p3_q[2];

  logic [31:0] sb [$];
  logic [15:0] seq_a [4];
  logic [15:0] seq_b [4];
  logic        seq_en [4];

  function automatic logic [31:0] ref_mul(input logic [1:0] op,
                                          input logic [31:0] a,
                                          input logic [31:0] b);
    logic [63:0] ae, be, p;
    ae = (op == 2'b01 || op == 2'b10) ? {{32{a[31]}}, a} : {32'h0, a};
    be = (op == 2'b01) ? {{32{b[31]}}, b} : {32'h0, b};
    p  = ae * be;
    return (op == 2'b00) ? p[31:0] : p[63:32];
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs,
                     input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input bit sel, input logic v, input logic [1:0] op,
                       input logic [31:0] a, input logic [31:0] b);
    if (sel) begin
      in_valid3 = v; in_op3 = op; in_a3 = a; in_b3 = b;
    end else begin
      in_valid1 = v; in_op1 = op; in_a1 = a; in_b1 = b;
    end
  endtask

  task automatic set_ready(input bit sel, input logic r);
    if (sel) out_ready3 = r;
    else     out_ready1 = r;
  endtask

  task automatic peek(input bit sel, output logic ov, output logic ir,
                      output logic bz, output logic en,
                      output logic [31:0] res,
                      output logic [15:0] ma, output logic [15:0] mb);
    if (sel) begin
      ov = out_valid3; ir = in_ready3; bz = busy3; en = mul_en3;
      res = out_result3; ma = mul_a3; mb = mul_b3;
    end else begin
      ov = out_valid1; ir = in_ready1; bz = busy1; en = mul_en1;
      res = out_result1; ma = mul_a1; mb = mul_b1;
    end
  endtask

  // mode: 0 = out_ready always high, 1 = random stalls, 2 = hold 20 cycles
  task automatic do_op(input bit sel, input logic [1:0] op,
                       input logic [31:0] a, input logic [31:0] b,
                       input logic [31:0] exp, input int mode, input bit junk);
    logic ov, ir, bz, en, r;
    logic [31:0] res;
    logic [15:0] ma, mb;
    int n, lat, stall;
    bit done;
    sb.push_back(exp);
    peek(sel, ov, ir, bz, en, res, ma, mb);
    chk("ready_before_accept", ir, 1'b1);
    set_ready(sel, 1'b0);
    drive(sel, 1'b1, op, a, b);
    tick();
    n = 1; lat = 0; stall = 0; done = 0;
    while (!done && n <= 200) begin
      drive(sel, (junk && n < 4) ? 1'($urandom_range(1)) : 1'b0,
            2'($urandom), $urandom, $urandom);
      peek(sel, ov, ir, bz, en, res, ma, mb);
      if (n <= 4) begin
        seq_a[n-1] = ma; seq_b[n-1] = mb; seq_en[n-1] = en;
      end
      if (n == 5) begin
        chk("mul_en_after_issue", en, 1'b0);
        chk("mul_a_after_issue", ma, 16'h0);
      end
      chk("ready_vs_busy", ir, !bz);
      if (ov) begin
        if (lat == 0) lat = n;
        chk("result", res, sb[0]);
        case (mode)
          0:       r = 1'b1;
          1:       r = ($urandom_range(99) >= 30);
          default: r = (stall >= 20);
        endcase
        if (!r) chk("stall_in_ready", ir, 1'b0);
        set_ready(sel, r);
        if (r) done = 1; else stall++;
      end else begin
        set_ready(sel, 1'b0);
      end
      tick();
      n++;
    end
    set_ready(sel, 1'b0);
    drive(sel, 1'b0, 2'b00, 32'h0, 32'h0);
    if (!done) begin
      chk("timeout", 32'd0, 32'd1);
      sb.delete();
    end else begin
      void'(sb.pop_front());
      peek(sel, ov, ir, bz, en, res, ma, mb);
      chk("in_ready_after_handshake", ir, 1'b1);
      chk("out_valid_after_handshake", ov, 1'b0);
      chk("latency", lat, sel ? 32'd9 : 32'd7);
    end
  endtask

  task automatic check_idle(input string tag);
    logic ov, ir, bz, en;
    logic [31:0] res;
    logic [15:0] ma, mb;
    peek(1'b0, ov, ir, bz, en, res, ma, mb);
    chk({tag, "_out_valid"}, ov, 1'b0);
    chk({tag, "_busy"}, bz, 1'b0);
    chk({tag, "_in_ready"}, ir, 1'b1);
    chk({tag, "_mul_en"}, en, 1'b0);
    chk({tag, "_out_result"}, res, 32'h0);
  endtask

  initial begin
    logic ov, ir, bz, en;
    logic [31:0] res, a, b;
    logic [15:0] ma, mb;
    logic [1:0] op;
    int w;

    reset1 = 1'b1; reset3 = 1'b1;
    drive(1'b0, 1'b0, 2'b00, 32'h0, 32'h0);
    drive(1'b1, 1'b0, 2'b00, 32'h0, 32'h0);
    out_ready1 = 1'b0; out_ready3 = 1'b0;
    tick(); tick();
    reset1 = 1'b0; reset3 = 1'b0;

    // Reset state
    check_idle("reset");
    peek(1'b0, ov, ir, bz, en, res, ma, mb);
    chk("reset_mul_a", ma, 16'h0);
    chk("reset_mul_b", mb, 16'h0);
    peek(1'b1, ov, ir, bz, en, res, ma, mb);
    chk("reset3_in_ready", ir, 1'b1);
    chk("reset3_busy", bz, 1'b0);

    // MUL with pass sequence check
    do_op(1'b0, 2'b00, 32'h00010002, 32'h00030004, 32'h000A0008, 0, 0);
    for (int unsigned k = 0; k < 4; k++) chk("seq_en", seq_en[k], 1'b1);
    chk("seq_a0", seq_a[0], 16'h0002); chk("seq_b0", seq_b[0], 16'h0004);
    chk("seq_a1", seq_a[1], 16'h0001); chk("seq_b1", seq_b[1], 16'h0004);
    chk("seq_a2", seq_a[2], 16'h0002); chk("seq_b2", seq_b[2], 16'h0003);
    chk("seq_a3", seq_a[3], 16'h0001); chk("seq_b3", seq_b[3], 16'h0003);

    // Signedness variants on all-ones operands
    do_op(1'b0, 2'b11, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFE, 0, 0);
    do_op(1'b0, 2'b01, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'h00000000, 0, 0);
    do_op(1'b0, 2'b10, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFF, 0, 0);

    // Back-pressure: 20 stalled cycles in DONE
    do_op(1'b0, 2'b11, 32'h12345678, 32'h9ABCDEF0, 32'h0B00EA4E, 2, 0);

    // Reset during ISSUE (second issue cycle)
    drive(1'b0, 1'b1, 2'b11, 32'hDEADBEEF, 32'hCAFEF00D);
    tick();
    drive(1'b0, 1'b0, 2'b00, 32'h0, 32'h0);
    tick();
    reset1 = 1'b1;
    tick();
    reset1 = 1'b0;
    check_idle("rst_issue");
    do_op(1'b0, 2'b00, 32'd3, 32'd5, 32'h0000000F, 0, 0);

    // Reset while holding a result in DONE
    drive(1'b0, 1'b1, 2'b11, 32'hFFFF0000, 32'h0000FFFF);
    tick();
    drive(1'b0, 1'b0, 2'b00, 32'h0, 32'h0);
    w = 0;
    while (!out_valid1 && w < 50) begin tick(); w++; end
    chk("done_reached", out_valid1, 1'b1);
    reset1 = 1'b1;
    tick();
    reset1 = 1'b0;
    check_idle("rst_done");
    do_op(1'b0, 2'b00, 32'd3, 32'd5, 32'h0000000F, 0, 0);

    // Random regression with stalls and junk inputs while busy
    for (int unsigned i = 0; i < 1500; i++) begin
      op = 2'($urandom);
      a  = $urandom; b = $urandom;
      case ($urandom_range(7))
        0: a = 32'h80000000;
        1: b = 32'hFFFFFFFF;
        2: a = 32'h7FFFFFFF;
        3: b = 32'h0;
        default: ;
      endcase
      do_op(1'b0, op, a, b, ref_mul(op, a, b), 1, 1);
    end

    // MUL_PIPE=3 instance
    do_op(1'b1, 2'b01, 32'h80000000, 32'h80000000, 32'h40000000, 0, 0);
    for (int unsigned i = 0; i < 60; i++) begin
      op = 2'($urandom);
      a  = $urandom; b = $urandom;
      do_op(1'b1, op, a, b, ref_mul(op, a, b), 1, 1);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
